hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline hazard controller for the 5-stage core (PC → IF_ID → Control Unit/CU mux → ID_EX → EX_MEM → MEM_WB).
- Keeps a shadow scoreboard of destination registers in EX/MEM/WB.
- Detects load-use hazards and stalls PC/IF_ID while injecting a NOP through the CU mux.
- Generates operand forwarding selects and the IF_ID flush for taken branches resolved in ID.
- Keeps saturating stall/flush performance counters.

Parameters:
- REG_W, 4, register-index width (R0–R15).
- CNT_W, 16, width of performance counters.
- PC_REG, 15, register index never forwarded or hazard-checked (PC reads come from the PC path).

Ports:
- clk  in  1  pipeline clock, rising edge.
- R  in  1  reset, asynchronous, active-low.
- ID_Rn  in  REG_W  first source register of the instruction in ID.
- ID_Rm  in  REG_W  second source register in ID.
- ID_Rd  in  REG_W  destination (store source when ID_use_Rd) in ID.
- ID_use_Rn, ID_use_Rm, ID_use_Rd  in  1 each  source actually read by the ID instruction.
- ID_RF_enable  in  1  ID instruction writes Rd.
- ID_load_instr  in  1  ID instruction is a load.
- branch_taken  in  1  branch/BL in ID resolved taken this cycle.
- PC_LE  out  1  PC load enable.
- IFID_LE  out  1  IF_ID load enable.
- IFID_flush  out  1  IF_ID synchronous clear to NOP.
- cu_nop  out  1  CU mux select; 1 forces all ID control signals to 0.
- fwd_A, fwd_B, fwd_C  out  2 each  operand source for Rn/Rm/Rd: 00 RF, 01 EX result, 10 MEM result, 11 WB result.
- ctl_state  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.
- stall_count  out  CNT_W  number of stall cycles.
- flush_count  out  CNT_W  number of flush cycles.

Behaviour:
- Shadow stages (registered):
  - EX slot: {EX_rd, EX_rfen, EX_load}.
  - MEM slot: {MEM_rd, MEM_rfen}.
  - WB slot: {WB_rd, WB_rfen}.
- Shadow advance, every rising clk:
  - MEM ← EX, WB ← MEM.
  - EX ← {ID_Rd, ID_RF_enable & ~cu_nop, ID_load_instr & ~cu_nop}.
  - When cu_nop=1 the EX slot receives a bubble (rfen=0, load=0).
- Match rule: stage X matches source S when X_rfen=1, X_rd==S, S!=PC_REG, and the use bit of S is set.
- Load-use hazard (combinational): EX_load=1 and the EX slot matches any used source.
- Outputs on load-use hazard, same cycle:
  - PC_LE=0, IFID_LE=0, cu_nop=1, IFID_flush=0.
  - branch_taken is ignored this cycle and re-evaluated after the stall.
- Outputs when there is no hazard and branch_taken=1:
  - PC_LE=1, IFID_LE=1, IFID_flush=1, cu_nop=0 (the branch itself proceeds; the fetched slot is squashed).
- Outputs otherwise: PC_LE=1, IFID_LE=1, IFID_flush=0, cu_nop=0.
- Forwarding selects (combinational), priority EX (01) > MEM (10) > WB (11) > RF (00).
  - During a load-use stall the selects still reflect the matches but are don't-care for checking.
- FSM (registered) records the action taken in the previous cycle:
  - Next state = STALL if hazard, else FLUSH if branch_taken, else RUN.
  - STALL cannot repeat for the same load: after one stall the load is in MEM, so hazard clears and forwarding selects 10.
  - FLUSH→STALL and STALL→FLUSH are legal.
- Counters:
  - stall_count increments each cycle the hazard is asserted; flush_count increments each cycle IFID_flush=1.
  - Both saturate at all-ones (no wrap).
- Reset (R=0, asynchronous):
  - All shadow rfen/load bits and rd fields = 0, ctl_state=RUN, both counters = 0.
  - Resulting outputs: PC_LE=1, IFID_LE=1, IFID_flush=0, cu_nop=0, fwd_*=00.
  - Reset asserted mid-stall clears the shadow immediately, so stall outputs drop in the same cycle.
- Latency: control outputs are combinational from ID inputs plus shadow; the shadow, FSM and counters update one cycle later.

Test Plan:
- Reset then idle, with ID_RF_enable=0 and no uses for 5 cycles → PC_LE=IFID_LE=1, cu_nop=0, fwd_*=00, counters=0, ctl_state=00.
- Back-to-back ALU hazards: ADD R1 (rfen=1) followed by SUB using Rn=R1 → fwd_A=01. Next cycle, an instruction using Rm=R1 → fwd_B=10. The cycle after, Rd-use of R1 → fwd_C=11.
- Load-use: LDR R2 followed by ADD with Rm=R2 → that cycle PC_LE=0, IFID_LE=0, cu_nop=1; next cycle ctl_state=01, no stall, fwd_B=10, stall_count=1.
- Branch taken with no hazard → IFID_flush=1 for one cycle, ctl_state=10 next cycle, flush_count=1; a later ADD to R3 shows no match from the bubble slot.
- Load-use coinciding with branch_taken=1 → IFID_flush=0, stall wins. Next cycle branch_taken=1 again → IFID_flush=1; totals stall_count=1, flush_count=1.
- Corner cases:
  - Writer to R15 followed by a reader of R15 → fwd=00, no stall.
  - Force stall_count to all-ones-1 via a 65535-cycle hazard loop → holds at 65535.
  - R pulled low mid-stall → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Hazard controller bus: ID-stage register usage in, pipeline control and
// forwarding selects out.
//   master : the pipeline side (drives the ID fields and branch_taken)
//   slave  : hazard_stall_controller
// Ports carried:
//   ID_Rn/ID_Rm/ID_Rd, ID_use_*   source/dest indices and their use bits
//   ID_RF_enable, ID_load_instr   ID instruction writes Rd / is a load
//   branch_taken                  branch in ID resolved taken
//   PC_LE, IFID_LE, IFID_flush    fetch-side control
//   cu_nop                        CU mux select (inject bubble)
//   fwd_A/fwd_B/fwd_C             operand sources for Rn/Rm/Rd
//   ctl_state                     action taken last cycle
//   stall_count, flush_count      saturating performance counters
interface hazard_stall_controller_if #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] ID_Rn;
    logic [REG_W-1:0] ID_Rm;
    logic [REG_W-1:0] ID_Rd;
    logic             ID_use_Rn;
    logic             ID_use_Rm;
    logic             ID_use_Rd;
    logic             ID_RF_enable;
    logic             ID_load_instr;
    logic             branch_taken;

    logic             PC_LE;
    logic             IFID_LE;
    logic             IFID_flush;
    logic             cu_nop;
    logic [1:0]       fwd_A;
    logic [1:0]       fwd_B;
    logic [1:0]       fwd_C;
    logic [1:0]       ctl_state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd,
               ID_RF_enable, ID_load_instr, branch_taken,
        input  PC_LE, IFID_LE, IFID_flush, cu_nop, fwd_A, fwd_B, fwd_C,
               ctl_state, stall_count, flush_count
    );

    modport slave (
        input  ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd,
               ID_RF_enable, ID_load_instr, branch_taken,
        output PC_LE, IFID_LE, IFID_flush, cu_nop, fwd_A, fwd_B, fwd_C,
               ctl_state, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller for the 5-stage core.
// Tracks destination registers of the instructions in EX/MEM/WB in a shadow
// scoreboard, stalls PC/IF_ID and injects a bubble on load-use hazards,
// squashes the fetched slot on a taken branch, and produces forwarding selects.
// Ports:
//   clk  pipeline clock, rising edge
//   R    asynchronous active-low reset
//   bus  hazard_stall_controller_if.slave (ID inputs, control/forwarding outputs)
module hazard_stall_controller #(
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PC_REG = 15
) (
    input logic                      clk,
    input logic                      R,
    hazard_stall_controller_if.slave bus
);
    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } state_e;

    localparam logic [REG_W-1:0] PcIdx  = REG_W'(PC_REG);
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Shadow scoreboard
    logic [REG_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic             ex_rfen_q, ex_load_q, mem_rfen_q, wb_rfen_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ex_a, ex_b, ex_c, mem_a, mem_b, mem_c, wb_a, wb_b, wb_c;
    logic hazard;
    logic flush;

    function automatic logic hit(input logic rfen, input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] src, input logic use_src);
        // PC reads come from the PC path, never from a pipeline stage.
        return rfen && (rd == src) && (src != PcIdx) && use_src;
    endfunction

    function automatic logic [1:0] sel(input logic h_ex, input logic h_mem, input logic h_wb);
        if (h_ex) return 2'b01;
        if (h_mem) return 2'b10;
        if (h_wb) return 2'b11;
        return 2'b00;
    endfunction

    assign ex_a  = hit(ex_rfen_q,  ex_rd_q,  bus.ID_Rn, bus.ID_use_Rn);
    assign ex_b  = hit(ex_rfen_q,  ex_rd_q,  bus.ID_Rm, bus.ID_use_Rm);
    assign ex_c  = hit(ex_rfen_q,  ex_rd_q,  bus.ID_Rd, bus.ID_use_Rd);
    assign mem_a = hit(mem_rfen_q, mem_rd_q, bus.ID_Rn, bus.ID_use_Rn);
    assign mem_b = hit(mem_rfen_q, mem_rd_q, bus.ID_Rm, bus.ID_use_Rm);
    assign mem_c = hit(mem_rfen_q, mem_rd_q, bus.ID_Rd, bus.ID_use_Rd);
    assign wb_a  = hit(wb_rfen_q,  wb_rd_q,  bus.ID_Rn, bus.ID_use_Rn);
    assign wb_b  = hit(wb_rfen_q,  wb_rd_q,  bus.ID_Rm, bus.ID_use_Rm);
    assign wb_c  = hit(wb_rfen_q,  wb_rd_q,  bus.ID_Rd, bus.ID_use_Rd);

    // Load data is not ready until MEM, so a consumer right behind it must wait.
    assign hazard = ex_load_q & (ex_a | ex_b | ex_c);
    // A stall holds IF_ID, so a coincident branch is re-seen after the stall.
    assign flush  = ~hazard & bus.branch_taken;

    assign bus.fwd_A       = sel(ex_a, mem_a, wb_a);
    assign bus.fwd_B       = sel(ex_b, mem_b, wb_b);
    assign bus.fwd_C       = sel(ex_c, mem_c, wb_c);
    assign bus.ctl_state   = state_q;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

    always_comb begin
        bus.PC_LE      = 1'b1;
        bus.IFID_LE    = 1'b1;
        bus.IFID_flush = 1'b0;
        bus.cu_nop     = 1'b0;
        state_d        = StRun;
        if (hazard) begin
            bus.PC_LE   = 1'b0;
            bus.IFID_LE = 1'b0;
            bus.cu_nop  = 1'b1;
            state_d     = StStall;
        end else if (flush) begin
            bus.IFID_flush = 1'b1;
            state_d        = StFlush;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            ex_rd_q     <= '0;
            ex_rfen_q   <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_rd_q    <= '0;
            mem_rfen_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_rfen_q   <= 1'b0;
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_rd_q     <= bus.ID_Rd;
            // The bubble keeps the Rd field but can never match.
            ex_rfen_q   <= bus.ID_RF_enable & ~hazard;
            ex_load_q   <= bus.ID_load_instr & ~hazard;
            mem_rd_q    <= ex_rd_q;
            mem_rfen_q  <= ex_rfen_q;
            wb_rd_q     <= mem_rd_q;
            wb_rfen_q   <= mem_rfen_q;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller. Each step drives one ID
// instruction, queues the hand-derived expected outputs, and compares them
// on the falling edge. Counters are 8 bits here so saturation is reachable.
module tb_hazard_stall_controller;
    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 8;

    // {PC_LE, IFID_LE, IFID_flush, cu_nop}
    localparam logic [3:0] CtlRun   = 4'b1100;
    localparam logic [3:0] CtlStall = 4'b0001;
    localparam logic [3:0] CtlFlush = 4'b1110;
    localparam logic [1:0] StRun    = 2'b00;
    localparam logic [1:0] StStall  = 2'b01;
    localparam logic [1:0] StFlush  = 2'b10;

    logic clk = 1'b0;
    logic R   = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    hazard_stall_controller #(
        .REG_W (REG_W),
        .CNT_W (CNT_W),
        .PC_REG(15)
    ) dut (
        .clk(clk),
        .R  (R),
        .bus(bus)
    );

    typedef struct {
        string      tag;
        logic [3:0] ctl;
        logic       chk_fwd;
        logic [5:0] fwd;   // {fwd_A, fwd_B, fwd_C}
        logic [1:0] st;
        int         sc;
        int         fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input logic [2:0] uses, input logic rfen, input logic load,
                         input logic br);
        bus.ID_Rn         = rn;
        bus.ID_Rm         = rm;
        bus.ID_Rd         = rd;
        bus.ID_use_Rn     = uses[2];
        bus.ID_use_Rm     = uses[1];
        bus.ID_use_Rd     = uses[0];
        bus.ID_RF_enable  = rfen;
        bus.ID_load_instr = load;
        bus.branch_taken  = br;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] ctl, input logic chk_fwd,
                            input logic [5:0] fwd, input logic [1:0] st, input int sc,
                            input int fc);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.chk_fwd = chk_fwd; e.fwd = fwd;
        e.st = st; e.sc = sc; e.fc = fc;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        e = sb.pop_front();
        check_eq({e.tag, ".ctl"},
                 32'({bus.PC_LE, bus.IFID_LE, bus.IFID_flush, bus.cu_nop}), 32'(e.ctl));
        if (e.chk_fwd)
            check_eq({e.tag, ".fwd"}, 32'({bus.fwd_A, bus.fwd_B, bus.fwd_C}), 32'(e.fwd));
        check_eq({e.tag, ".state"}, 32'(bus.ctl_state), 32'(e.st));
        check_eq({e.tag, ".stall_cnt"}, 32'(bus.stall_count), 32'(e.sc));
        check_eq({e.tag, ".flush_cnt"}, 32'(bus.flush_count), 32'(e.fc));
    endtask

    // Drive just after the rising edge, check on the falling edge.
    task automatic step(input string tag, input logic [3:0] rn, input logic [3:0] rm,
                        input logic [3:0] rd, input logic [2:0] uses, input logic rfen,
                        input logic load, input logic br, input logic [3:0] e_ctl,
                        input logic chk_fwd, input logic [5:0] e_fwd, input logic [1:0] e_st,
                        input int e_sc, input int e_fc);
        @(posedge clk);
        #1;
        drive(rn, rm, rd, uses, rfen, load, br);
        push_exp(tag, e_ctl, chk_fwd, e_fwd, e_st, e_sc, e_fc);
        @(negedge clk);
        observe();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with all uses set against R0: an empty shadow must not match.
        drive(4'd0, 4'd0, 4'd0, 3'b111, 1'b1, 1'b1, 1'b0);
        #12;
        push_exp("reset", CtlRun, 1'b1, 6'b000000, StRun, 0, 0);
        observe();
        drive(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        R = 1'b1;

        for (int i = 0; i < 5; i++)
            step("idle", 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0,
                 CtlRun, 1'b1, 6'b000000, StRun, 0, 0);

        // ALU forwarding from EX, MEM, WB
        step("add_r1",  4'd0, 4'd0, 4'd1, 3'b000, 1'b1, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 0, 0);
        step("fwd_ex",  4'd1, 4'd0, 4'd4, 3'b100, 1'b1, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b010000, StRun, 0, 0);
        step("fwd_mem", 4'd0, 4'd1, 4'd5, 3'b010, 1'b1, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b001000, StRun, 0, 0);
        step("fwd_wb",  4'd0, 4'd0, 4'd1, 3'b001, 1'b0, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000011, StRun, 0, 0);

        // Load-use stall, then the held ADD picks the load up from MEM
        step("ldr_r2",  4'd0, 4'd0, 4'd2, 3'b000, 1'b1, 1'b1, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 0, 0);
        step("ld_use",  4'd0, 4'd2, 4'd6, 3'b010, 1'b1, 1'b0, 1'b0,
             CtlStall, 1'b0, 6'b000000, StRun, 0, 0);
        step("ld_fwd",  4'd0, 4'd2, 4'd6, 3'b010, 1'b1, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b001000, StStall, 1, 0);

        // Taken branch, squashed slot, then R6 found in WB past the bubbles
        step("branch",  4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1,
             CtlFlush, 1'b1, 6'b000000, StRun, 1, 0);
        step("squash",  4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000000, StFlush, 1, 1);
        step("add_r3",  4'd0, 4'd6, 4'd3, 3'b110, 1'b1, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b001100, StRun, 1, 1);

        // Load-use coinciding with a taken branch: stall first, flush after
        step("ldr_r7",  4'd0, 4'd0, 4'd7, 3'b000, 1'b1, 1'b1, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 1, 1);
        step("ld_br",   4'd7, 4'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1,
             CtlStall, 1'b0, 6'b000000, StRun, 1, 1);
        step("br_after", 4'd7, 4'd0, 4'd0, 3'b100, 1'b0, 1'b0, 1'b1,
             CtlFlush, 1'b1, 6'b100000, StStall, 2, 1);
        step("post_br", 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000000, StFlush, 2, 2);

        // R15 is never forwarded nor hazard-checked, even from a load
        step("ldr_pc",  4'd0, 4'd0, 4'd15, 3'b000, 1'b1, 1'b1, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 2, 2);
        step("rd_pc",   4'd15, 4'd15, 4'd15, 3'b111, 1'b0, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 2, 2);
        step("rd_pc2",  4'd15, 4'd15, 4'd15, 3'b111, 1'b0, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 2, 2);

        // Reset asserted mid-stall drops the stall with no clock edge
        step("ldr_r8",  4'd0, 4'd0, 4'd8, 3'b000, 1'b1, 1'b1, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 2, 2);
        step("ld_use8", 4'd8, 4'd0, 4'd9, 3'b100, 1'b1, 1'b0, 1'b0,
             CtlStall, 1'b0, 6'b000000, StRun, 2, 2);
        #2;
        R = 1'b0;
        #1;
        push_exp("rst_mid", CtlRun, 1'b1, 6'b000000, StRun, 0, 0);
        observe();

        // Self-dependent load stream: stall on every other cycle
        drive(4'd2, 4'd0, 4'd2, 3'b100, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        R = 1'b1;
        repeat (508) @(posedge clk);
        step("sat254",  4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 254, 0);
        drive(4'd2, 4'd0, 4'd2, 3'b100, 1'b1, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        step("sat255",  4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000000, StStall, 255, 0);
        step("sat_hold", 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0,
             CtlRun, 1'b1, 6'b000000, StRun, 255, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
